ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_rr_pick.sv | 24 ++
 rtl/ram_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// the default geometry of the RAM interface and the burst limit.
package ram_arbiter_pkg;

  // Arbiter ownership states. IDLE re-arbitrates every cycle, OWNx keeps
  // the RAM with port x until it releases the lock or is forced out.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefMaxBurst = 16;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin selector. With a single requester that requester
// wins; with both requesting, the port that was not served last wins.
module rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_served_i,
  output logic [1:0] gnt_o
);

  // Pick at most one winner; bit 0 is port 0, bit 1 is port 1.
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o = last_served_i ? 2'b01 : 2'b10;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single external synchronous RAM.
// Ports may lock the RAM for a burst; a locked owner is forced out after
// MAX_BURST beats if the other port is waiting.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DefAddrW,
  parameter int DATA_W    = DefDataW,
  parameter int MAX_BURST = DefMaxBurst
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              write0_i,
  input  logic              write1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  input  logic [ADDR_W-1:0] address0_i,
  input  logic [ADDR_W-1:0] address1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_write_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic            last_served_q, last_served_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0] cnt_sat_inc;
  logic [CntW-1:0] cnt_after;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic [1:0]      rr_gnt;
  logic            gnt0, gnt1;
  logic            acc0, acc1;

  rr_pick u_rr_pick (
    .req0_i        (req0_i),
    .req1_i        (req1_i),
    .last_served_i (last_served_q),
    .gnt_o         (rr_gnt)
  );

  // Grant: owner holds the RAM unconditionally, otherwise round-robin;
  // nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n_i) begin
      unique case (state_q)
        OWN0:    gnt0 = 1'b1;
        OWN1:    gnt1 = 1'b1;
        default: begin
          gnt0 = rr_gnt[0];
          gnt1 = rr_gnt[1];
        end
      endcase
    end
  end

  assign acc0   = req0_i & gnt0;
  assign acc1   = req1_i & gnt1;
  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;

  // RAM side: route the granted port, zeros when nobody holds a grant.
  // The write strobe needs an actual accepted write beat.
  always_comb begin
    ram_address_o = '0;
    ram_data_o    = '0;
    if (gnt0) begin
      ram_address_o = address0_i;
      ram_data_o    = data0_i;
    end else if (gnt1) begin
      ram_address_o = address1_i;
      ram_data_o    = data1_i;
    end
    ram_write_o = (acc0 & write0_i) | (acc1 & write1_i);
  end

  // Burst counter increment that sticks at MAX_BURST.
  always_comb begin
    cnt_sat_inc = (beat_cnt_q == MaxCnt) ? MaxCnt : beat_cnt_q + CntW'(1);
  end

  // Next state, burst count and round-robin history. The forced exit
  // looks at the count after this cycle's beat, so the beat that reaches
  // MAX_BURST is the owner's last one when the other port is waiting.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_served_d = last_served_q;
    cnt_after     = beat_cnt_q;

    if (acc0) begin
      last_served_d = 1'b0;
    end else if (acc1) begin
      last_served_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (acc0 && lock0_i) begin
          state_d    = OWN0;
          beat_cnt_d = CntW'(1);
        end else if (acc1 && lock1_i) begin
          state_d    = OWN1;
          beat_cnt_d = CntW'(1);
        end
      end
      OWN0: begin
        if (acc0) begin
          cnt_after = cnt_sat_inc;
        end
        beat_cnt_d = cnt_after;
        if ((cnt_after == MaxCnt && req1_i) || !lock0_i) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (acc1) begin
          cnt_after = cnt_sat_inc;
        end
        beat_cnt_d = cnt_after;
        if ((cnt_after == MaxCnt && req0_i) || !lock1_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A read beat accepted now produces exactly one rvalid next cycle.
  always_comb begin
    rvalid0_d = acc0 & ~write0_i;
    rvalid1_d = acc1 & ~write1_i;
  end

  // Arbiter state registers; reset drops ownership and pending reads,
  // and leaves port 0 first in line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
    end
  end

  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign data0_o   = ram_data_i;
  assign data1_o   = ram_data_i;

  // Grants are mutually exclusive by construction; catch any regression.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(gnt0 && gnt1));
    end
  end

endmodule
